// File: rtl/morra_match_driver_if.sv
// Host/game-facing signal bundle for the morra match driver.
// The slave modport is the driver's view; the master modport is the host/game side.
interface morra_match_driver_if #(
   parameter int LFSR_W = 8
);
   logic              START;
   logic [3:0]        LEN;
   logic [LFSR_W-1:0] SEED;
   logic [1:0]        MANCHE;
   logic [1:0]        PARTITA;
   logic [1:0]        PRIMO;
   logic [1:0]        SECONDO;
   logic              INIZIO;
   logic              BUSY;
   logic              DONE;
   logic [1:0]        RESULT;
   logic              ABORT;
   logic [3:0]        WINS1;
   logic [3:0]        WINS2;
   logic [3:0]        DRAWS;
   logic [1:0]        fsm_state;

   // START is a single-cycle request with no ready: it is taken only when the
   // driver is idle (fsm_state == 0) and silently dropped otherwise.
   modport slave (
      input  START, LEN, SEED, MANCHE, PARTITA,
      output PRIMO, SECONDO, INIZIO, BUSY, DONE, RESULT, ABORT,
             WINS1, WINS2, DRAWS, fsm_state
   );

   modport master (
      output START, LEN, SEED, MANCHE, PARTITA,
      input  PRIMO, SECONDO, INIZIO, BUSY, DONE, RESULT, ABORT,
             WINS1, WINS2, DRAWS, fsm_state
   );
endinterface

// File: rtl/morra_match_driver.sv
// Opponent-side driver for the morra cinese game: starts a match, feeds one
// LFSR-generated move pair per cycle, tallies MANCHE and reports the PARTITA outcome.
module morra_match_driver #(
   parameter int LFSR_W  = 8,
   parameter int TIMEOUT = 63
) (
   input  logic clk,
   input  logic rst_n,
   morra_match_driver_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_INIT = 2'd1,
      S_PLAY = 2'd2
   } state_t;

   // Galois right-shift mask; x^8+x^6+x^5+x^4+1 for the 8-bit case.
   localparam logic [LFSR_W-1:0] TAPS = (LFSR_W == 8) ? LFSR_W'(8'hB8)
                                      : LFSR_W'((1 << (LFSR_W-1)) | (1 << (LFSR_W-2)));
   localparam logic [5:0] LAST_CYCLE = 6'(TIMEOUT - 1);

   state_t            state_q, state_d;
   logic [LFSR_W-1:0] lfsr1_q, lfsr1_d, lfsr2_q, lfsr2_d, seed_eff;
   logic [1:0]        win_q, win_d, move_q, move_d;
   logic [5:0]        cnt_q, cnt_d;
   logic [1:0]        primo_q, primo_d, secondo_q, secondo_d, result_q, result_d;
   logic              inizio_q, inizio_d, busy_q, busy_d, done_q, done_d, abort_q, abort_d;
   logic [3:0]        wins1_q, wins1_d, wins2_q, wins2_d, draws_q, draws_d;

   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
      return l[0] ? ((l >> 1) ^ TAPS) : (l >> 1);
   endfunction

   function automatic logic [LFSR_W-1:0] bit_rev(input logic [LFSR_W-1:0] l);
      logic [LFSR_W-1:0] r;
      for (int i = 0; i < LFSR_W; i++) r[i] = l[LFSR_W-1-i];
      return r;
   endfunction

   // A player who just won may not repeat the winning move: rotate it instead.
   function automatic logic [1:0] pick_move(input logic [1:0] raw, input logic [1:0] self_code,
                                            input logic [1:0] win, input logic [1:0] move);
      logic [1:0] m;
      m = (raw == 2'b00) ? 2'b01 : raw;
      if (win == self_code && m == move) m = (m == 2'b11) ? 2'b01 : m + 2'b01;
      return m;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      lfsr1_d   = lfsr1_q;
      lfsr2_d   = lfsr2_q;
      win_d     = win_q;
      move_d    = move_q;
      cnt_d     = cnt_q;
      primo_d   = primo_q;
      secondo_d = secondo_q;
      result_d  = result_q;
      inizio_d  = 1'b0;
      busy_d    = busy_q;
      done_d    = 1'b0;
      abort_d   = abort_q;
      wins1_d   = wins1_q;
      wins2_d   = wins2_q;
      draws_d   = draws_q;
      seed_eff  = (bus.SEED == '0) ? LFSR_W'(1) : bus.SEED;
      case (state_q)
         S_IDLE: begin
            if (bus.START) begin
               state_d   = S_INIT;
               lfsr1_d   = seed_eff;
               lfsr2_d   = bit_rev(seed_eff);
               // Winner memory is per match, so a new match starts unconstrained.
               win_d     = 2'b00;
               move_d    = 2'b00;
               cnt_d     = '0;
               result_d  = 2'b00;
               abort_d   = 1'b0;
               wins1_d   = '0;
               wins2_d   = '0;
               draws_d   = '0;
               busy_d    = 1'b1;
               inizio_d  = 1'b1;
               primo_d   = bus.LEN[3:2];
               secondo_d = bus.LEN[1:0];
            end
         end
         S_INIT: begin
            state_d   = S_PLAY;
            primo_d   = pick_move(lfsr1_q[1:0], 2'b01, win_q, move_q);
            secondo_d = pick_move(lfsr2_q[1:0], 2'b10, win_q, move_q);
            lfsr1_d   = lfsr_step(lfsr1_q);
            lfsr2_d   = lfsr_step(lfsr2_q);
         end
         S_PLAY: begin
            // The round closing at this edge already constrains the next move pair.
            case (bus.MANCHE)
               2'b01: begin
                  win_d  = 2'b01;
                  move_d = primo_q;
                  if (wins1_q != 4'hF) wins1_d = wins1_q + 4'd1;
               end
               2'b10: begin
                  win_d  = 2'b10;
                  move_d = secondo_q;
                  if (wins2_q != 4'hF) wins2_d = wins2_q + 4'd1;
               end
               2'b11: begin
                  win_d = 2'b11;
                  if (draws_q != 4'hF) draws_d = draws_q + 4'd1;
               end
               default: ;
            endcase
            if (bus.PARTITA != 2'b00 || cnt_q == LAST_CYCLE) begin
               state_d   = S_IDLE;
               result_d  = bus.PARTITA;
               abort_d   = (bus.PARTITA == 2'b00);
               done_d    = 1'b1;
               busy_d    = 1'b0;
               primo_d   = 2'b00;
               secondo_d = 2'b00;
            end else begin
               cnt_d     = cnt_q + 6'd1;
               primo_d   = pick_move(lfsr1_q[1:0], 2'b01, win_d, move_d);
               secondo_d = pick_move(lfsr2_q[1:0], 2'b10, win_d, move_d);
               lfsr1_d   = lfsr_step(lfsr1_q);
               lfsr2_d   = lfsr_step(lfsr2_q);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr1_q   <= LFSR_W'(1);
         lfsr2_q   <= LFSR_W'(1);
         win_q     <= 2'b00;
         move_q    <= 2'b00;
         cnt_q     <= '0;
         primo_q   <= 2'b00;
         secondo_q <= 2'b00;
         result_q  <= 2'b00;
         inizio_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         abort_q   <= 1'b0;
         wins1_q   <= '0;
         wins2_q   <= '0;
         draws_q   <= '0;
      end else begin
         lfsr1_q   <= lfsr1_d;
         lfsr2_q   <= lfsr2_d;
         win_q     <= win_d;
         move_q    <= move_d;
         cnt_q     <= cnt_d;
         primo_q   <= primo_d;
         secondo_q <= secondo_d;
         result_q  <= result_d;
         inizio_q  <= inizio_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         abort_q   <= abort_d;
         wins1_q   <= wins1_d;
         wins2_q   <= wins2_d;
         draws_q   <= draws_d;
      end
   end

   assign bus.PRIMO     = primo_q;
   assign bus.SECONDO   = secondo_q;
   assign bus.INIZIO    = inizio_q;
   assign bus.BUSY      = busy_q;
   assign bus.DONE      = done_q;
   assign bus.RESULT    = result_q;
   assign bus.ABORT     = abort_q;
   assign bus.WINS1     = wins1_q;
   assign bus.WINS2     = wins2_q;
   assign bus.DRAWS     = draws_q;
   assign bus.fsm_state = state_q;
endmodule

// File: tb/tb_morra_match_driver.sv
// Randomized bench for morra_match_driver: a move/tally reference model plays the
// game side and scores every driven move pair and every end-of-match report.
module tb_morra_match_driver;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   morra_match_driver_if #(.LFSR_W(8)) bus ();
   morra_match_driver #(.LFSR_W(8), .TIMEOUT(63)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_cmp = 0;
   int n_err = 0;
   int m_l1, m_l2, m_win, m_move, m_w1, m_w2, m_dr;
   logic [3:0] exp_q[$];
   logic [3:0] seq_a[$];
   logic [3:0] seq_b[$];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: plain-integer LFSR arithmetic and game rules.
   function automatic int lfsr_next(input int x);
      return (x % 2 == 1) ? ((x / 2) ^ 'hB8) : (x / 2);
   endfunction

   function automatic int rev8(input int x);
      int r = 0;
      for (int i = 0; i < 8; i++) if ((x >> i) % 2 == 1) r += 1 << (7 - i);
      return r;
   endfunction

   function automatic int pick(input int l, input int self_code);
      int m = l % 4;
      if (m == 0) m = 1;
      if (m_win == self_code && m == m_move) m = (m % 3) + 1;
      return m;
   endfunction

   task automatic model_start(input int seed);
      int s = seed % 256;
      if (s == 0) s = 1;
      m_l1 = s; m_l2 = rev8(s);
      m_win = 0; m_move = 0; m_w1 = 0; m_w2 = 0; m_dr = 0;
      exp_q.delete();
   endtask

   task automatic model_next_pair();
      int p1 = pick(m_l1, 1);
      int p2 = pick(m_l2, 2);
      m_l1 = lfsr_next(m_l1);
      m_l2 = lfsr_next(m_l2);
      exp_q.push_back(4'(p1 * 4 + p2));
   endtask

   task automatic model_round(input int man, input int p1, input int p2);
      if (man == 1) begin m_w1 = (m_w1 < 15) ? m_w1 + 1 : 15; m_win = 1; m_move = p1; end
      if (man == 2) begin m_w2 = (m_w2 < 15) ? m_w2 + 1 : 15; m_win = 2; m_move = p2; end
      if (man == 3) begin m_dr = (m_dr < 15) ? m_dr + 1 : 15; m_win = 3; end
   endtask

   // mode 0 random game, 1 P1 always wins, 2 never ends, 3 forced P1 win on carta,
   // 4 fixed round pattern never ending, 5 like 2 but PARTITA on the timeout cycle.
   task automatic run_match(input int seed, input int len, input int mode, input int rec,
                            output int ncycles);
      logic [3:0] e;
      int man, par, limit, exp_res, exp_abort, k;
      bit prop_pending = 0;
      @(negedge clk);
      bus.START = 1'b1; bus.SEED = 8'(seed); bus.LEN = 4'(len);
      model_start(seed);
      @(negedge clk);
      bus.START = (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.SEED  = 8'($urandom);
      check_val("init_inizio", 32'(bus.INIZIO), 1);
      check_val("init_len", 32'({bus.PRIMO, bus.SECONDO}), 32'(len));
      check_val("init_busy", 32'(bus.BUSY), 1);
      check_val("init_wins1", 32'(bus.WINS1), 0);
      model_next_pair();
      limit = (mode == 3) ? 8 : $urandom_range(1, 20);
      exp_res = 0; exp_abort = 0; ncycles = 0;
      for (k = 1; k <= 63; k++) begin
         @(negedge clk);
         e = exp_q.pop_front();
         check_val("primo", 32'(bus.PRIMO), 32'(e[3:2]));
         check_val("secondo", 32'(bus.SECONDO), 32'(e[1:0]));
         check_val("play_busy_done", 32'({bus.INIZIO, bus.BUSY, bus.DONE}), 32'b010);
         if (prop_pending) check_val("rule_no_repeat", 32'(bus.PRIMO != 2'b10), 1);
         prop_pending = 0;
         if (rec == 1) seq_a.push_back({bus.PRIMO, bus.SECONDO});
         if (rec == 2) seq_b.push_back({bus.PRIMO, bus.SECONDO});
         man = $urandom_range(0, 3);
         par = 0;
         case (mode)
            0: par = (k >= limit) ? $urandom_range(1, 3) : 0;
            1: begin man = 1; par = (m_w1 + 1 >= 4 + len) ? 1 : 0; end
            3: begin
               if (e[3:2] == 2'b10) begin man = 1; prop_pending = 1; end
               par = (k >= limit) ? 1 : 0;
            end
            4: man = k % 4;
            5: par = (k == 63) ? 2 : 0;
            default: ;
         endcase
         bus.MANCHE  = 2'(man);
         bus.PARTITA = 2'(par);
         if (mode == 0 || mode == 2) begin
            bus.START = 1'($urandom_range(0, 1));
            bus.SEED  = 8'($urandom);
         end
         model_round(man, int'(e[3:2]), int'(e[1:0]));
         ncycles = k;
         if (par != 0) begin exp_res = par; break; end
         if (k == 63) exp_abort = 1;
         else model_next_pair();
      end
      @(negedge clk);
      bus.START = 1'b0; bus.MANCHE = 2'b00; bus.PARTITA = 2'b00;
      check_val("end_done", 32'(bus.DONE), 1);
      check_val("end_busy", 32'(bus.BUSY), 0);
      check_val("end_result", 32'(bus.RESULT), 32'(exp_res));
      check_val("end_abort", 32'(bus.ABORT), 32'(exp_abort));
      check_val("end_wins1", 32'(bus.WINS1), 32'(m_w1));
      check_val("end_wins2", 32'(bus.WINS2), 32'(m_w2));
      check_val("end_draws", 32'(bus.DRAWS), 32'(m_dr));
      check_val("end_moves", 32'({bus.PRIMO, bus.SECONDO}), 0);
      check_val("end_state", 32'(bus.fsm_state), 0);
      @(negedge clk);
      check_val("done_pulse", 32'(bus.DONE), 0);
   endtask

   task automatic check_reset_values(input string tag);
      check_val({tag, "_moves"}, 32'({bus.PRIMO, bus.SECONDO}), 0);
      check_val({tag, "_flags"}, 32'({bus.INIZIO, bus.BUSY, bus.DONE, bus.ABORT}), 0);
      check_val({tag, "_result"}, 32'(bus.RESULT), 0);
      check_val({tag, "_tallies"}, 32'({bus.WINS1, bus.WINS2, bus.DRAWS}), 0);
      check_val({tag, "_state"}, 32'(bus.fsm_state), 0);
   endtask

   initial begin
      int n;
      rst_n = 1'b0;
      bus.START = 1'b0; bus.LEN = 4'd0; bus.SEED = 8'd0; bus.MANCHE = 2'b00; bus.PARTITA = 2'b00;
      #1;
      check_reset_values("reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // P1 wins every round, LEN=0: match over after 4 manches.
      run_match($urandom_range(0, 255), 0, 1, 0, n);
      check_val("p1_sweep_len", 32'(n), 4);

      // Random games, random LEN, START noise during play.
      for (int i = 0; i < 40; i++) run_match($urandom_range(0, 255), $urandom_range(0, 15), 0, 0, n);

      // Never-ending game: abort on the 63rd play cycle.
      run_match($urandom_range(0, 255), $urandom_range(0, 15), 2, 0, n);
      check_val("timeout_len", 32'(n), 63);
      run_match($urandom_range(0, 255), 3, 5, 0, n);
      check_val("timeout_partita_wins", 32'(n), 63);

      // SEED=0 must reproduce SEED=1.
      seq_a.delete(); seq_b.delete();
      run_match(0, 2, 4, 1, n);
      run_match(1, 2, 4, 2, n);
      check_val("seed0_len", 32'(seq_a.size()), 32'(seq_b.size()));
      for (int i = 0; i < seq_a.size() && i < seq_b.size(); i++)
         check_val("seed0_seq", 32'(seq_a[i]), 32'(seq_b[i]));

      // Winner may not repeat carta, across many seeds.
      for (int i = 0; i < 1000; i++) run_match($urandom_range(0, 255), $urandom_range(0, 15), 3, 0, n);

      // Asynchronous reset in the middle of play.
      @(negedge clk);
      bus.START = 1'b1; bus.SEED = 8'($urandom); bus.LEN = 4'd5;
      @(negedge clk);
      bus.START = 1'b0;
      repeat (5) begin
         @(negedge clk);
         bus.MANCHE = 2'($urandom_range(1, 3));
      end
      check_val("pre_reset_busy", 32'(bus.BUSY), 1);
      rst_n = 1'b0;
      #1;
      check_reset_values("midreset");
      @(negedge clk);
      rst_n = 1'b1; bus.MANCHE = 2'b00;
      repeat (3) begin
         @(negedge clk);
         check_val("post_reset_idle", 32'({bus.BUSY, bus.DONE, bus.fsm_state}), 0);
      end

      // A normal match still runs after the reset.
      run_match($urandom_range(0, 255), 7, 0, 0, n);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
